bcp_scan_controller: RTL and testbench
======================================

Name: bcp_scan_controller

Overview:
- Sequences Boolean constraint propagation (BCP) over the clause store for the SAT solver.
- Scans clauses 0..num_clauses-1, one clause at a time:
  - reads the clause (mask, pole and variable indices) from clause memory;
  - classifies it against the live variable-assignment table;
  - hands each unit-clause implication to the assignment owner over a valid/ready handshake.
- Repeats full passes until a pass produces no implication (fixpoint) or a conflict is found.
- Sits between the clause RAM, the variable table and the decision/backtrack FSM.

Parameters:
VAR_PER_CLAUSE, 5, literal slots per clause
NUM_VARIABLE, 128, variables in the assignment table
VAR_W, 7, variable index width (log2 NUM_VARIABLE)
NUM_CLAUSE, 1023, clause store depth
CL_W, 10, clause index width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin BCP; accepted only in IDLE
abort  in  1  synchronous cancel; return to IDLE next cycle
num_clauses  in  CL_W  clauses in the active formula; sampled on start
cl_rd_en  out  1  clause read strobe
cl_rd_addr  out  CL_W  clause read address
cl_mask  in  VAR_PER_CLAUSE  slot-valid bits; valid 1 cycle after cl_rd_en
cl_pole  in  VAR_PER_CLAUSE  literal polarity per slot (1 = positive)
cl_var  in  VAR_PER_CLAUSE*VAR_W  variable index per slot; slot i at [i*VAR_W +: VAR_W]
var_assigned  in  NUM_VARIABLE  1 = variable assigned
var_value  in  NUM_VARIABLE  assigned value
imp_valid  out  1  implication offered
imp_ready  in  1  implication accepted
imp_var  out  VAR_W  implied variable
imp_value  out  1  implied value (= pole of the sole open slot)
imp_clause  out  CL_W  antecedent clause index
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at scan end
conflict  out  1  sticky until next accepted start
conflict_clause  out  CL_W  first falsified clause; sticky with conflict
pass_count  out  16  completed passes this run; saturates at 16'hFFFF

Behaviour:
- Reset (rst_n = 0 at posedge) drives every output register low:
  - state = IDLE, imp_valid = 0, cl_rd_en = 0, done = 0, conflict = 0;
  - conflict_clause = 0, pass_count = 0, busy = 0.
- Reset or abort mid-scan discards the in-flight read and any pending implication. abort has priority over all transitions except reset.
- Per-slot terms (only slots with mask = 1 participate):
  - open: var_assigned[v] = 0.
  - true: assigned and var_value[v] == pole.
- Clause classification:
  - SAT: any slot true.
  - UNIT: not SAT and exactly one open slot.
  - CONFLICT: not SAT, zero open slots and mask != 0.
  - OTHER: everything else, including mask = 0.
- States:
  - IDLE: on start, latch num_clauses, clear conflict, conflict_clause and pass_count, set idx = 0, pass_imp = 0.
    - num_clauses == 0 -> DONE.
    - otherwise -> FETCH.
    - start outside IDLE is ignored.
  - FETCH: cl_rd_en = 1 and cl_rd_addr = idx for exactly one cycle -> EVAL.
  - EVAL: register clause data and var tables, classify.
    - CONFLICT: conflict = 1, conflict_clause = idx -> DONE.
    - UNIT: load imp_* -> EMIT.
    - SAT/OTHER -> NEXT.
  - EMIT: imp_valid held high with imp_* stable until imp_ready is sampled high.
    - On handshake: drop imp_valid, set pass_imp = 1 -> NEXT.
    - imp_ready high on the first EMIT cycle gives a single-cycle handshake.
  - NEXT:
    - idx < num_clauses-1: idx++ -> FETCH.
    - Otherwise the pass ends: pass_count++ (saturating).
      - pass_imp = 1: idx = 0, pass_imp = 0 -> FETCH.
      - pass_imp = 0 -> DONE.
  - DONE: done = 1 for one cycle -> IDLE.
- Latency: 3 cycles per non-unit clause (FETCH, EVAL, NEXT). A unit clause adds EMIT cycles until the handshake.
- The variable table owner must update on the imp handshake edge. The controller reads var tables only in EVAL, so the next clause always sees the new assignment.
- A UNIT whose variable was assigned by another agent before EVAL is reclassified naturally. No stale implication is re-emitted.
- Index arithmetic is unsigned CL_W wide. idx never exceeds num_clauses-1 and never wraps.

Test Plan:
- num_clauses = 0, start -> busy for 1 cycle, done pulse, conflict = 0, pass_count = 0, no cl_rd_en.
- 2 clauses {x1}, {~x1 v x2}, all unassigned, imp_ready = 1:
  - pass 1 emits (var1, 1, cl 0) then (var2, 1, cl 1);
  - pass 2 emits nothing;
  - done with pass_count = 2, conflict = 0.
- Clauses {x3}, {~x3}, imp_ready tied 1 and table updated on handshake:
  - emits (var3, 1, cl 0);
  - clause 1 gives conflict = 1, conflict_clause = 1, done pulse, no further imp_valid.
- imp_ready held low 10 cycles on the first implication -> imp_valid and imp_* stable all 10 cycles, no cl_rd_en until the handshake.
- abort asserted during EMIT -> next cycle IDLE, imp_valid = 0, busy = 0, no done. A following start rescans from clause 0 with conflict cleared.
- rst_n low during EVAL of clause 5 -> all outputs 0, state IDLE. A start while busy (pulse mid-pass) is ignored and does not change pass_count.

Source files
------------

// File: rtl/bcp_scan_controller_if.sv
// Clause-read and implication-handshake bundle for the BCP scan controller.
// master = controller side, slave = clause RAM / assignment owner side.
interface bcp_scan_controller_if #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int VAR_W          = 7,
  parameter int CL_W           = 10
);
  // Clause read port: data is valid one cycle after cl_rd_en.
  logic                            cl_rd_en;
  logic [CL_W-1:0]                 cl_rd_addr;
  logic [VAR_PER_CLAUSE-1:0]       cl_mask;
  logic [VAR_PER_CLAUSE-1:0]       cl_pole;
  logic [VAR_PER_CLAUSE*VAR_W-1:0] cl_var;

  // Implication handshake towards the variable-table owner.
  logic                            imp_valid;
  logic                            imp_ready;
  logic [VAR_W-1:0]                imp_var;
  logic                            imp_value;
  logic [CL_W-1:0]                 imp_clause;

  modport master (
    output cl_rd_en, cl_rd_addr, imp_valid, imp_var, imp_value, imp_clause,
    input  cl_mask, cl_pole, cl_var, imp_ready
  );

  modport slave (
    input  cl_rd_en, cl_rd_addr, imp_valid, imp_var, imp_value, imp_clause,
    output cl_mask, cl_pole, cl_var, imp_ready
  );
endinterface

// File: rtl/bcp_scan_controller.sv
// BCP scan controller: walks clauses 0..num_clauses-1, classifies each one
// against the live assignment table, offers unit implications, and repeats
// full passes until a fixpoint or a conflict.
module bcp_scan_controller #(
  parameter int VAR_PER_CLAUSE = 5,
  parameter int NUM_VARIABLE   = 128,
  parameter int VAR_W          = 7,
  parameter int NUM_CLAUSE     = 1023,
  parameter int CL_W           = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CL_W-1:0]         num_clauses,
  bcp_scan_controller_if.master   bus,
  input  logic [NUM_VARIABLE-1:0] var_assigned,
  input  logic [NUM_VARIABLE-1:0] var_value,
  output logic                    busy,
  output logic                    done,
  output logic                    conflict,
  output logic [CL_W-1:0]         conflict_clause,
  output logic [15:0]             pass_count
);

  localparam int CNT_W = $clog2(VAR_PER_CLAUSE + 1);
  // Highest index the clause store can hold; idx is never advanced past it.
  localparam logic [CL_W-1:0] MAX_IDX = CL_W'(NUM_CLAUSE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EVAL, S_EMIT, S_NEXT, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CL_W-1:0]   idx;
  logic [CL_W-1:0]   num_q;
  logic              pass_imp;
  logic [VAR_W-1:0]  imp_var_q;
  logic              imp_value_q;
  logic [CL_W-1:0]   imp_clause_q;

  logic              any_true;
  logic [CNT_W-1:0]  open_cnt;
  logic [VAR_W-1:0]  open_var;
  logic              open_pole;
  logic              is_unit;
  logic              is_conflict;
  logic              last_clause;

  // Classify the clause currently on the read-data bus against the tables.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip an assignment would infer a latch.
    any_true  = 1'b0;
    open_cnt  = '0;
    open_var  = '0;
    open_pole = 1'b0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (bus.cl_mask[i]) begin
        if (!var_assigned[bus.cl_var[i*VAR_W +: VAR_W]]) begin
          open_cnt  = open_cnt + CNT_W'(1);
          open_var  = bus.cl_var[i*VAR_W +: VAR_W];
          open_pole = bus.cl_pole[i];
        end else if (var_value[bus.cl_var[i*VAR_W +: VAR_W]] == bus.cl_pole[i]) begin
          any_true = 1'b1;
        end
      end
    end
  end

  assign is_unit     = !any_true && (open_cnt == CNT_W'(1));
  assign is_conflict = !any_true && (open_cnt == '0) && (|bus.cl_mask);
  assign last_clause = (idx == num_q - CL_W'(1)) || (idx == MAX_IDX);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (num_clauses == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_EVAL;
      S_EVAL: begin
        if (is_conflict)  state_nxt = S_DONE;
        else if (is_unit) state_nxt = S_EMIT;
        else              state_nxt = S_NEXT;
      end
      S_EMIT:  if (bus.imp_ready) state_nxt = S_NEXT;
      S_NEXT:  state_nxt = (!last_clause || pass_imp) ? S_FETCH : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Scan index, pass bookkeeping, conflict capture and implication payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx             <= '0;
      num_q           <= '0;
      pass_imp        <= 1'b0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      pass_count      <= '0;
      imp_var_q       <= '0;
      imp_value_q     <= 1'b0;
      imp_clause_q    <= '0;
    end else if (!abort) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            num_q           <= num_clauses;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            pass_count      <= '0;
            idx             <= '0;
            pass_imp        <= 1'b0;
          end
        end
        S_EVAL: begin
          if (is_conflict) begin
            conflict        <= 1'b1;
            conflict_clause <= idx;
          end else if (is_unit) begin
            imp_var_q    <= open_var;
            imp_value_q  <= open_pole;
            imp_clause_q <= idx;
          end
        end
        S_EMIT: if (bus.imp_ready) pass_imp <= 1'b1;
        S_NEXT: begin
          if (!last_clause) begin
            idx <= idx + CL_W'(1);
          end else begin
            if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            if (pass_imp) begin
              idx      <= '0;
              pass_imp <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cl_rd_en   = (state == S_FETCH);
  assign bus.cl_rd_addr = idx;
  assign bus.imp_valid  = (state == S_EMIT);
  assign bus.imp_var    = imp_var_q;
  assign bus.imp_value  = imp_value_q;
  assign bus.imp_clause = imp_clause_q;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

endmodule

// File: tb/tb_bcp_scan_controller.sv
// Bench for bcp_scan_controller: clause RAM and variable-table owner models,
// a pass-level BCP reference model, and a per-cycle compare process.
module tb_bcp_scan_controller;

  localparam int VPC  = 5;
  localparam int NV   = 128;
  localparam int VW   = 7;
  localparam int CLW  = 10;
  localparam int MEMD = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [CLW-1:0] num_clauses = '0;
  logic [NV-1:0]  var_assigned;
  logic [NV-1:0]  var_value;
  logic           busy, done, conflict;
  logic [CLW-1:0] conflict_clause;
  logic [15:0]    pass_count;

  bcp_scan_controller_if #(.VAR_PER_CLAUSE(VPC), .VAR_W(VW), .CL_W(CLW)) bus ();

  bcp_scan_controller #(
    .VAR_PER_CLAUSE(VPC), .NUM_VARIABLE(NV), .VAR_W(VW), .NUM_CLAUSE(1023), .CL_W(CLW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_clauses(num_clauses),
    .bus(bus), .var_assigned(var_assigned), .var_value(var_value),
    .busy(busy), .done(done), .conflict(conflict),
    .conflict_clause(conflict_clause), .pass_count(pass_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- clause RAM (one-cycle read latency) ----------------
  logic [VPC-1:0] m_mask [MEMD];
  logic [VPC-1:0] m_pole [MEMD];
  logic [VW-1:0]  m_var  [MEMD][VPC];

  always @(posedge clk) begin
    if (bus.cl_rd_en) begin
      bus.cl_mask <= m_mask[bus.cl_rd_addr[5:0]];
      bus.cl_pole <= m_pole[bus.cl_rd_addr[5:0]];
      for (int i = 0; i < VPC; i++)
        bus.cl_var[i*VW +: VW] <= m_var[bus.cl_rd_addr[5:0]][i];
    end
  end

  task automatic clear_mem();
    for (int c = 0; c < MEMD; c++) begin
      m_mask[c] = '0;
      m_pole[c] = '0;
      for (int i = 0; i < VPC; i++) m_var[c][i] = '0;
    end
  endtask

  task automatic set_lit(input int c, input int slot, input int v, input logic pole);
    m_mask[c][slot] = 1'b1;
    m_pole[c][slot] = pole;
    m_var[c][slot]  = VW'(v);
  endtask

  // ------------- variable-table owner: updates on the handshake edge -------------
  logic          tbl_load = 1'b0;
  logic [NV-1:0] init_a = '0;
  logic [NV-1:0] init_v = '0;

  always @(posedge clk) begin
    if (tbl_load) begin
      var_assigned <= init_a;
      var_value    <= init_v;
    end else if (bus.imp_valid && bus.imp_ready) begin
      var_assigned[bus.imp_var] <= 1'b1;
      var_value[bus.imp_var]    <= bus.imp_value;
    end
  end

  task automatic load_table(input logic [NV-1:0] a, input logic [NV-1:0] v);
    init_a   = a;
    init_v   = v;
    tbl_load = 1'b1;
    tick();
    tbl_load = 1'b0;
  endtask

  // imp_ready driver: 0 = random, 1 = always ready, 2 = never ready.
  int ready_mode = 1;
  initial begin
    bus.imp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.imp_ready = 1'($urandom_range(0, 1));
        1:       bus.imp_ready = 1'b1;
        default: bus.imp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- reference model (whole-run, pass level) ----------------
  typedef struct { int v; int val; int cl; } imp_t;
  imp_t exp_imps[$];
  int   exp_reads[$];
  int   exp_conf, exp_cc, exp_pass;
  int   run_id = 0;

  function automatic void run_model(input int n, input logic [NV-1:0] a_in, input logic [NV-1:0] v_in);
    logic [NV-1:0] a = a_in;
    logic [NV-1:0] v = v_in;
    bit any_imp;
    exp_imps.delete();
    exp_reads.delete();
    exp_conf = 0;
    exp_cc   = 0;
    exp_pass = 0;
    if (n == 0) return;
    while (1) begin
      any_imp = 0;
      for (int c = 0; c < n; c++) begin
        int opens = 0;
        int ov = 0;
        int op = 0;
        bit sat = 0;
        exp_reads.push_back(c);
        for (int i = 0; i < VPC; i++) begin
          if (m_mask[c][i]) begin
            if (!a[m_var[c][i]]) begin
              opens++;
              ov = int'(m_var[c][i]);
              op = int'(m_pole[c][i]);
            end else if (v[m_var[c][i]] == m_pole[c][i]) begin
              sat = 1;
            end
          end
        end
        if (!sat && opens == 0 && m_mask[c] != '0) begin
          exp_conf = 1;
          exp_cc   = c;
          return;
        end
        if (!sat && opens == 1) begin
          exp_imps.push_back('{ov, op, c});
          a[ov]   = 1'b1;
          v[ov]   = op[0];
          any_imp = 1;
        end
      end
      if (exp_pass < 65535) exp_pass++;
      if (!any_imp) return;
    end
  endfunction

  // ---------------- per-cycle compare process ----------------
  int   done_count = 0;
  int   seen_run = 0;
  int   rd_ptr = 0;
  int   imp_ptr = 0;
  bit   hold = 0;
  imp_t held;

  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run = run_id;
      rd_ptr   = 0;
      imp_ptr  = 0;
      hold     = 0;
    end
    if (rst_n) begin
      if (bus.cl_rd_en) begin
        if (rd_ptr >= exp_reads.size()) check("extra_read", 1, 0);
        else begin
          check("rd_addr", 32'(bus.cl_rd_addr), exp_reads[rd_ptr]);
          rd_ptr++;
        end
        check("rd_during_imp", 32'(bus.imp_valid), 0);
      end
      if (bus.imp_valid) begin
        if (hold) begin
          check("imp_var_stable", 32'(bus.imp_var), held.v);
          check("imp_value_stable", 32'(bus.imp_value), held.val);
          check("imp_clause_stable", 32'(bus.imp_clause), held.cl);
        end else if (imp_ptr >= exp_imps.size()) begin
          check("extra_imp", 1, 0);
        end else begin
          held = exp_imps[imp_ptr];
          imp_ptr++;
          check("imp_var", 32'(bus.imp_var), held.v);
          check("imp_value", 32'(bus.imp_value), held.val);
          check("imp_clause", 32'(bus.imp_clause), held.cl);
        end
        hold = !bus.imp_ready;
      end else begin
        hold = 0;
      end
      if (done) begin
        check("done_conflict", 32'(conflict), exp_conf);
        check("done_conflict_clause", 32'(conflict_clause), exp_cc);
        check("done_pass_count", 32'(pass_count), exp_pass);
        check("reads_consumed", rd_ptr, exp_reads.size());
        check("imps_consumed", imp_ptr, exp_imps.size());
        done_count++;
      end
    end
  end

  // ---------------- run helpers ----------------
  task automatic start_run(input int n);
    run_model(n, var_assigned, var_value);
    run_id++;
    num_clauses = CLW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int dc0);
    for (int k = 0; k < 20000 && done_count == dc0; k++) tick();
    check({tag, "_timeout"}, 32'(done_count != dc0), 1);
    tick();
  endtask

  task automatic do_run(input string tag, input int n);
    int dc0 = done_count;
    start_run(n);
    wait_done(tag, dc0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_conflict"}, 32'(conflict), 0);
    check({tag, "_conflict_clause"}, 32'(conflict_clause), 0);
    check({tag, "_pass_count"}, 32'(pass_count), 0);
    check({tag, "_cl_rd_en"}, 32'(bus.cl_rd_en), 0);
    check({tag, "_cl_rd_addr"}, 32'(bus.cl_rd_addr), 0);
    check({tag, "_imp_valid"}, 32'(bus.imp_valid), 0);
    check({tag, "_imp_fields"}, {bus.imp_var, bus.imp_value, bus.imp_clause}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int dc0;
    logic [NV-1:0] ra, rv;

    clear_mem();
    ready_mode = 1;
    init_a = '0;
    init_v = '0;
    tbl_load = 1'b1;
    repeat (3) tick();
    tbl_load = 1'b0;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Empty formula: one busy cycle with done, no reads.
    dc0 = done_count;
    start_run(0);
    check("n0_busy", 32'(busy), 1);
    check("n0_done", 32'(done), 1);
    check("n0_rd_en", 32'(bus.cl_rd_en), 0);
    tick();
    check("n0_busy_after", 32'(busy), 0);
    check("n0_done_after", 32'(done), 0);
    check("n0_pass_count", 32'(pass_count), 0);
    check("n0_done_seen", done_count, dc0 + 1);

    // {x1}, {~x1 v x2}: two implications then a quiet pass.
    clear_mem();
    set_lit(0, 0, 1, 1'b1);
    set_lit(1, 0, 1, 1'b0);
    set_lit(1, 3, 2, 1'b1);
    load_table('0, '0);
    run_model(2, var_assigned, var_value);
    check("model2_imp_count", exp_imps.size(), 2);
    check("model2_imp0", {exp_imps[0].v, exp_imps[0].val, exp_imps[0].cl}, {32'd1, 32'd1, 32'd0});
    check("model2_imp1", {exp_imps[1].v, exp_imps[1].val, exp_imps[1].cl}, {32'd2, 32'd1, 32'd1});
    check("model2_pass", exp_pass, 2);
    do_run("two_clause", 2);
    check("two_clause_pass_count", 32'(pass_count), 2);
    check("two_clause_conflict", 32'(conflict), 0);

    // {x3}, {~x3}: implication then conflict on clause 1.
    clear_mem();
    set_lit(0, 2, 3, 1'b1);
    set_lit(1, 4, 3, 1'b0);
    load_table('0, '0);
    run_model(2, var_assigned, var_value);
    check("model3_conf", exp_conf, 1);
    check("model3_cc", exp_cc, 1);
    check("model3_pass", exp_pass, 0);
    do_run("conflict", 2);
    check("conflict_sticky", 32'(conflict), 1);
    check("conflict_clause_sticky", 32'(conflict_clause), 1);
    repeat (3) tick();
    check("conflict_still_sticky", 32'(conflict), 1);

    // imp_ready held low: payload stable, no reads until the handshake.
    clear_mem();
    set_lit(0, 0, 1, 1'b1);
    set_lit(1, 0, 1, 1'b0);
    set_lit(1, 3, 2, 1'b1);
    load_table('0, '0);
    ready_mode = 2;
    dc0 = done_count;
    start_run(2);
    for (int k = 0; k < 50 && !bus.imp_valid; k++) tick();
    check("hold_var", 32'(bus.imp_var), 1);
    check("hold_clause", 32'(bus.imp_clause), 0);
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", 32'(bus.imp_valid), 1);
      check("hold_no_read", 32'(bus.cl_rd_en), 0);
      tick();
    end
    ready_mode = 1;
    wait_done("hold", dc0);

    // abort during EMIT, then a clean rescan from clause 0.
    clear_mem();
    set_lit(0, 1, 4, 1'b0);
    load_table('0, '0);
    ready_mode = 2;
    dc0 = done_count;
    start_run(1);
    for (int k = 0; k < 50 && !bus.imp_valid; k++) tick();
    check("abort_in_emit", 32'(bus.imp_valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_imp_valid", 32'(bus.imp_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    repeat (4) tick();
    check("abort_no_done", done_count, dc0);
    ready_mode = 1;
    do_run("after_abort", 1);
    check("after_abort_pass", 32'(pass_count), 2);
    check("after_abort_conflict", 32'(conflict), 0);

    // Reset during EVAL of clause 5.
    clear_mem();
    ra = '0;
    rv = '0;
    for (int c = 0; c < 8; c++) begin
      set_lit(c, c % VPC, 10 + c, 1'b1);
      ra[10 + c] = 1'b1;
      rv[10 + c] = 1'b1;
    end
    load_table(ra, rv);
    start_run(8);
    for (int k = 0; k < 200 && !(bus.cl_rd_en && bus.cl_rd_addr == 5); k++) tick();
    check("reached_clause5", 32'(bus.cl_rd_addr), 5);
    tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(busy), 0);

    // start pulsed mid-pass is ignored.
    dc0 = done_count;
    start_run(8);
    repeat (7) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_start", dc0);
    check("busy_start_pass", 32'(pass_count), 1);

    // Randomized formulas against the model with random imp_ready.
    ready_mode = 0;
    for (int r = 0; r < 30; r++) begin
      int n = $urandom_range(1, 12);
      clear_mem();
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          set_lit(c, $urandom_range(0, VPC - 1), $urandom_range(0, 11), 1'($urandom_range(0, 1)));
        end else begin
          for (int i = 0; i < VPC; i++)
            if ($urandom_range(0, 1) == 1)
              set_lit(c, i, $urandom_range(0, 11), 1'($urandom_range(0, 1)));
        end
      end
      ra = '0;
      rv = '0;
      for (int v = 0; v < 12; v++) begin
        ra[v] = ($urandom_range(0, 9) < 3);
        rv[v] = 1'($urandom_range(0, 1));
      end
      load_table(ra, rv);
      do_run("random", n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
